// File: rtl/lc3b_pipe_stage.sv
// LC-3b stage-boundary register: valid/ready handshake around one instruction bundle,
// optional two-entry skid buffer, synchronous flush to bubble, saturating stall counter.
module lc3b_pipe_stage #(
  parameter int WORD_WIDTH   = 16,
  parameter int CS_WIDTH     = 20,
  parameter int REG_ID_WIDTH = 3,
  parameter bit SKID_EN      = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WORD_WIDTH-1:0]   in_npc_i,
  input  logic [WORD_WIDTH-1:0]   in_ir_i,
  input  logic [WORD_WIDTH-1:0]   in_data0_i,
  input  logic [WORD_WIDTH-1:0]   in_data1_i,
  input  logic [CS_WIDTH-1:0]     in_cs_i,
  input  logic [2:0]              in_cc_i,
  input  logic [REG_ID_WIDTH-1:0] in_drid_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WORD_WIDTH-1:0]   out_npc_o,
  output logic [WORD_WIDTH-1:0]   out_ir_o,
  output logic [WORD_WIDTH-1:0]   out_data0_o,
  output logic [WORD_WIDTH-1:0]   out_data1_o,
  output logic [CS_WIDTH-1:0]     out_cs_o,
  output logic [2:0]              out_cc_o,
  output logic [REG_ID_WIDTH-1:0] out_drid_o,
  output logic [15:0]             stall_count_o
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0]   npc;
    logic [WORD_WIDTH-1:0]   ir;
    logic [WORD_WIDTH-1:0]   data0;
    logic [WORD_WIDTH-1:0]   data1;
    logic [CS_WIDTH-1:0]     cs;
    logic [2:0]              cc;
    logic [REG_ID_WIDTH-1:0] drid;
  } bundle_t;

  bundle_t     in_b, m_q, m_d;
  logic        valid;
  logic        accept, drain;
  logic [15:0] stall_q;

  assign in_b = '{npc: in_npc_i, ir: in_ir_i, data0: in_data0_i, data1: in_data1_i,
                  cs: in_cs_i, cc: in_cc_i, drid: in_drid_i};

  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign drain  = valid & out_ready_i;

  if (SKID_EN) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    state_e  state_q, state_d;
    bundle_t s_q, s_d;
    logic    rdy_q;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= EMPTY;
        m_q     <= '0;
        s_q     <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        m_q     <= m_d;
        s_q     <= s_d;
        // Registered ready keeps out_ready off the upstream ready path.
        rdy_q   <= (state_d != TWO);
      end
    end

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      unique case (state_q)
        EMPTY: if (accept) begin
          m_d     = in_b;
          state_d = ONE;
        end
        ONE: begin
          unique case ({accept, drain})
            2'b11: m_d = in_b;
            2'b01: state_d = EMPTY;
            2'b10: begin
              s_d     = in_b;
              state_d = TWO;
            end
            default: ;
          endcase
        end
        TWO: if (drain) begin
          m_d     = s_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
      if (flush_i) begin
        state_d = EMPTY;
        m_d     = m_q;
        s_d     = s_q;
      end
    end

    assign valid      = (state_q != EMPTY);
    assign in_ready_o = rdy_q;
  end else begin : g_single
    logic vld_q, vld_d;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_q <= 1'b0;
        m_q   <= '0;
      end else begin
        vld_q <= vld_d;
        m_q   <= m_d;
      end
    end

    always_comb begin
      m_d   = m_q;
      vld_d = vld_q;
      if (accept) begin
        m_d   = in_b;
        vld_d = 1'b1;
      end else if (drain) begin
        vld_d = 1'b0;
      end
      if (flush_i) vld_d = 1'b0;
    end

    assign valid      = vld_q;
    assign in_ready_o = ~vld_q | out_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)                                          stall_q <= '0;
    else if (valid && !out_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  // An empty stage must look like a NOP downstream, so only cs is gated.
  assign out_valid_o   = valid;
  assign out_npc_o     = m_q.npc;
  assign out_ir_o      = m_q.ir;
  assign out_data0_o   = m_q.data0;
  assign out_data1_o   = m_q.data1;
  assign out_cs_o      = valid ? m_q.cs : '0;
  assign out_cc_o      = m_q.cc;
  assign out_drid_o    = m_q.drid;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// Drives a skid (index 0) and a single-entry (index 1) stage with shared stimulus and
// checks both against a FIFO scoreboard plus independent ready/valid/stall models.
module tb_lc3b_pipe_stage;

  typedef struct packed {
    logic [15:0] npc;
    logic [15:0] ir;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [19:0] cs;
    logic [2:0]  cc;
    logic [2:0]  drid;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  bun_t        ib = '0;

  logic        rdy [2];
  logic        ov  [2];
  logic [15:0] o_npc [2];
  logic [15:0] o_ir  [2];
  logic [15:0] o_d0  [2];
  logic [15:0] o_d1  [2];
  logic [19:0] o_cs  [2];
  logic [2:0]  o_cc  [2];
  logic [2:0]  o_drid [2];
  logic [15:0] sc [2];

  always #5 clk = ~clk;

  lc3b_pipe_stage #(.SKID_EN(1'b1)) dut_skid (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .in_npc_i(ib.npc), .in_ir_i(ib.ir), .in_data0_i(ib.d0), .in_data1_i(ib.d1),
    .in_cs_i(ib.cs), .in_cc_i(ib.cc), .in_drid_i(ib.drid),
    .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_npc_o(o_npc[0]), .out_ir_o(o_ir[0]), .out_data0_o(o_d0[0]), .out_data1_o(o_d1[0]),
    .out_cs_o(o_cs[0]), .out_cc_o(o_cc[0]), .out_drid_o(o_drid[0]), .stall_count_o(sc[0]));

  lc3b_pipe_stage #(.SKID_EN(1'b0)) dut_flat (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .in_npc_i(ib.npc), .in_ir_i(ib.ir), .in_data0_i(ib.d0), .in_data1_i(ib.d1),
    .in_cs_i(ib.cs), .in_cc_i(ib.cc), .in_drid_i(ib.drid),
    .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_npc_o(o_npc[1]), .out_ir_o(o_ir[1]), .out_data0_o(o_d0[1]), .out_data1_o(o_d1[1]),
    .out_cs_o(o_cs[1]), .out_cc_o(o_cc[1]), .out_drid_o(o_drid[1]), .stall_count_o(sc[1]));

  bun_t        q0[$];
  bun_t        q1[$];
  logic [15:0] msc [2];
  int          errs = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bun_t mk(input logic [15:0] ir);
    bun_t b;
    b.ir   = ir;
    b.npc  = ir + 16'd2;
    b.d0   = ~ir;
    b.d1   = ir ^ 16'hA5A5;
    b.cs   = {4'hC, ir ^ 16'h0F0F};
    b.cc   = (ir[2:0] == 3'd0) ? 3'b010 : ir[2:0];
    b.drid = ir[5:3];
    return b;
  endfunction

  function automatic int occ(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bun_t head(input int k);
    if (occ(k) == 0) return '0;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit mrdy(input int k);
    if (k == 0) return q0.size() != 2;
    return (q1.size() == 0) || out_ready;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string p;
      bun_t  h;
      p = (k == 0) ? "skid" : "flat";
      h = head(k);
      chk({p, ".out_valid"}, 32'(ov[k]), 32'(occ(k) != 0));
      chk({p, ".in_ready"}, 32'(rdy[k]), 32'(mrdy(k)));
      chk({p, ".out_cs"}, 32'(o_cs[k]), (occ(k) != 0) ? 32'(h.cs) : 32'd0);
      chk({p, ".stall"}, 32'(sc[k]), 32'(msc[k]));
      if (occ(k) != 0) begin
        chk({p, ".out_ir"}, 32'(o_ir[k]), 32'(h.ir));
        chk({p, ".out_npc"}, 32'(o_npc[k]), 32'(h.npc));
        chk({p, ".out_d0"}, 32'(o_d0[k]), 32'(h.d0));
        chk({p, ".out_d1"}, 32'(o_d1[k]), 32'(h.d1));
        chk({p, ".out_cc"}, 32'(o_cc[k]), 32'(h.cc));
        chk({p, ".out_drid"}, 32'(o_drid[k]), 32'(h.drid));
      end
    end
  endtask

  // One cycle: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input bit v, input logic [15:0] ir, input bit ordy, input bit fl, input bit r);
    bit acc [2];
    bit drn [2];
    bit stl [2];
    in_valid  = v;
    ib        = mk(ir);
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    if (chk_en) check_all();
    for (int k = 0; k < 2; k++) begin
      acc[k] = v && mrdy(k) && !fl;
      drn[k] = (occ(k) != 0) && ordy;
      stl[k] = (occ(k) != 0) && !ordy;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        if (k == 0) q0.delete(); else q1.delete();
        msc[k] = 16'd0;
      end else begin
        if (stl[k] && msc[k] != 16'hFFFF) msc[k] = msc[k] + 16'd1;
        if (fl) begin
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          if (drn[k]) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          if (acc[k]) begin
            if (k == 0) q0.push_back(ib); else q1.push_back(ib);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    msc[0] = '0;
    msc[1] = '0;
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    chk_en = 1'b1;

    // Reset/idle: all payload registers cleared.
    step(0, 16'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("rst.ir", 32'(o_ir[k]), 32'd0);
      chk("rst.npc", 32'(o_npc[k]), 32'd0);
      chk("rst.d0", 32'(o_d0[k]), 32'd0);
      chk("rst.d1", 32'(o_d1[k]), 32'd0);
      chk("rst.cc", 32'(o_cc[k]), 32'd0);
      chk("rst.drid", 32'(o_drid[k]), 32'd0);
    end

    // Full-rate streaming.
    for (int i = 0; i < 5; i++) step(1, 16'h1000 + 16'(i), 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);

    // Back-pressure: skid fills to two entries, then drains in order.
    step(1, 16'h1111, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 0, 0);
    repeat (3) step(0, 16'h0, 1, 0, 0);

    // Flush while full with a valid input that must be discarded.
    step(1, 16'h4444, 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    step(1, 16'h3333, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);
    step(1, 16'h6666, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);

    // Toggling downstream ready under continuous input.
    for (int i = 0; i < 8; i++) step(1, 16'h7000 + 16'(i), (i % 2) == 0, 0, 0);
    repeat (3) step(0, 16'h0, 1, 0, 0);

    // Random traffic with occasional flush and one mid-stream reset.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, 16'($urandom_range(0, 16'hFFFF)), ($urandom % 3) != 0,
           ($urandom % 23) == 0, i == 150);
    repeat (3) step(0, 16'h0, 1, 0, 0);

    // Stall counter saturation, then reset clears it.
    step(1, 16'h8888, 0, 0, 0);
    chk_en = 1'b0;
    repeat (70000) step(0, 16'h0, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 16'h0, 0, 0, 0);
    chk("skid.sat", 32'(sc[0]), 32'hFFFF);
    chk("flat.sat", 32'(sc[1]), 32'hFFFF);
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 0);
    chk("skid.sat_rst", 32'(sc[0]), 32'd0);
    chk("flat.sat_rst", 32'(sc[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
